// File: rtl/coproc_run_monitor_if.sv
// Monitor-side bundle: observed coprocessor status, run control, counters and trace read port.
interface coproc_run_monitor_if #(
  parameter int unsigned NB    = 4,
  parameter int unsigned NI    = 4,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned EW    = TS_W + 1 + NB + NI;

  logic             start;
  logic             A_bank;
  logic [NB-1:0]    B_bank;
  logic [NI-1:0]    incident;
  logic             done;
  logic             busy;
  logic             finished;
  logic             timed_out;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] a_sw_cnt;
  logic [CNT_W-1:0] b_sw_cnt;
  logic [CNT_W-1:0] inc_cnt;
  logic             tr_rd;
  logic [EW-1:0]    tr_data;
  logic             tr_valid;
  logic [LVL_W-1:0] tr_level;
  logic             tr_ovf;

  modport master (
    output start, A_bank, B_bank, incident, done, tr_rd,
    input  busy, finished, timed_out, cycle_cnt, a_sw_cnt, b_sw_cnt, inc_cnt,
           tr_data, tr_valid, tr_level, tr_ovf
  );

  modport slave (
    input  start, A_bank, B_bank, incident, done, tr_rd,
    output busy, finished, timed_out, cycle_cnt, a_sw_cnt, b_sw_cnt, inc_cnt,
           tr_data, tr_valid, tr_level, tr_ovf
  );
endinterface

// File: rtl/coproc_run_monitor.sv
// Run monitor: measures run length, counts bank switches / incident edges,
// logs every status change into a first-word-fall-through trace FIFO, enforces a timeout.
module coproc_run_monitor #(
  parameter int unsigned NB      = 4,
  parameter int unsigned NI      = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TS_W    = 16,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  coproc_run_monitor_if.slave  mon
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = TS_W + 1 + NB + NI;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_END = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d, finished_q, finished_d, timed_out_q, timed_out_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, a_sw_q, a_sw_d, b_sw_q, b_sw_d, inc_q, inc_d;
  logic             prev_a_q, prev_a_d;
  logic [NB-1:0]    prev_b_q, prev_b_d;
  logic [NI-1:0]    prev_inc_q, prev_inc_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]    mem_q [DEPTH];

  logic [PW-1:0]    level_c;
  logic             empty_c, full_c, push_c, pop_c, wr_en_c, clr_c;
  logic [EW-1:0]    entry_c;
  logic [NI-1:0]    rise_c;
  logic [CNT_W-1:0] rise_cnt_c;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Next-state, counter and FIFO pointer logic
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    finished_d  = finished_q;
    timed_out_d = timed_out_q;
    ovf_d       = ovf_q;
    cycle_cnt_d = cycle_cnt_q;
    a_sw_d      = a_sw_q;
    b_sw_d      = b_sw_q;
    inc_d       = inc_q;
    prev_a_d    = prev_a_q;
    prev_b_d    = prev_b_q;
    prev_inc_d  = prev_inc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    push_c      = 1'b0;
    clr_c       = 1'b0;
    wr_en_c     = 1'b0;

    level_c = wr_ptr_q - rd_ptr_q;
    empty_c = (level_c == '0);
    full_c  = (level_c == PW'(DEPTH));
    pop_c   = mon.tr_rd && !empty_c;
    entry_c = {cycle_cnt_q[TS_W-1:0], mon.A_bank, mon.B_bank, mon.incident};

    rise_c     = mon.incident & ~prev_inc_q;
    rise_cnt_c = '0;
    for (int i = 0; i < NI; i++) rise_cnt_c = rise_cnt_c + CNT_W'(rise_c[i]);

    case (state_q)
      S_RUN: begin
        cycle_cnt_d = sat_add(cycle_cnt_q, CNT_W'(1));
        if (mon.A_bank != prev_a_q) a_sw_d = sat_add(a_sw_q, CNT_W'(1));
        if (mon.B_bank != prev_b_q) b_sw_d = sat_add(b_sw_q, CNT_W'(1));
        inc_d  = sat_add(inc_q, rise_cnt_c);
        push_c = (mon.A_bank != prev_a_q) || (mon.B_bank != prev_b_q) ||
                 (mon.incident != prev_inc_q);
        prev_a_d   = mon.A_bank;
        prev_b_d   = mon.B_bank;
        prev_inc_d = mon.incident;
        // done takes priority over a coinciding timeout
        if (mon.done) begin
          state_d    = S_END;
          busy_d     = 1'b0;
          finished_d = 1'b1;
        end else if (cycle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = S_END;
          busy_d      = 1'b0;
          timed_out_d = 1'b1;
        end
      end
      S_IDLE, S_END: begin
        if (mon.start) begin
          clr_c       = 1'b1;
          state_d     = S_RUN;
          busy_d      = 1'b1;
          finished_d  = 1'b0;
          timed_out_d = 1'b0;
          cycle_cnt_d = '0;
          a_sw_d      = '0;
          b_sw_d      = '0;
          inc_d       = '0;
          prev_a_d    = mon.A_bank;
          prev_b_d    = mon.B_bank;
          prev_inc_d  = mon.incident;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    if (clr_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop_c) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_c && (!full_c || pop_c)) begin
        wr_en_c  = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else if (push_c) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      timed_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      cycle_cnt_q <= '0;
      a_sw_q      <= '0;
      b_sw_q      <= '0;
      inc_q       <= '0;
      prev_a_q    <= 1'b0;
      prev_b_q    <= '0;
      prev_inc_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      timed_out_q <= timed_out_d;
      ovf_q       <= ovf_d;
      cycle_cnt_q <= cycle_cnt_d;
      a_sw_q      <= a_sw_d;
      b_sw_q      <= b_sw_d;
      inc_q       <= inc_d;
      prev_a_q    <= prev_a_d;
      prev_b_q    <= prev_b_d;
      prev_inc_q  <= prev_inc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q[AW-1:0]] <= entry_c;
  end

  assign mon.busy      = busy_q;
  assign mon.finished  = finished_q;
  assign mon.timed_out = timed_out_q;
  assign mon.cycle_cnt = cycle_cnt_q;
  assign mon.a_sw_cnt  = a_sw_q;
  assign mon.b_sw_cnt  = b_sw_q;
  assign mon.inc_cnt   = inc_q;
  assign mon.tr_valid  = !empty_c;
  assign mon.tr_level  = level_c;
  assign mon.tr_ovf    = ovf_q;
  assign mon.tr_data   = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: tb/tb_coproc_run_monitor.sv
// Directed bench for coproc_run_monitor: trace entries are predicted into a queue
// as stimulus is driven and compared as they are popped.
module tb_coproc_run_monitor;
  localparam int unsigned NB    = 4;
  localparam int unsigned NI    = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned TS_W  = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned EW    = TS_W + 1 + NB + NI;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  coproc_run_monitor_if #(.NB(NB), .NI(NI), .CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) m ();
  coproc_run_monitor_if #(.NB(NB), .NI(NI), .CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) t ();

  coproc_run_monitor #(.NB(NB), .NI(NI), .CNT_W(CNT_W), .DEPTH(DEPTH), .TS_W(TS_W),
                       .TIMEOUT(200)) u_main (.clk(clk), .rst(rst), .mon(m.slave));
  coproc_run_monitor #(.NB(NB), .NI(NI), .CNT_W(CNT_W), .DEPTH(DEPTH), .TS_W(TS_W),
                       .TIMEOUT(20))  u_tmo  (.clk(clk), .rst(rst), .mon(t.slave));

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q [$];
  logic          pa;
  logic [NB-1:0] pb;
  logic [NI-1:0] pi;
  int            m_a, m_b, m_inc, m_cyc;
  logic          m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One RUN cycle on the main instance, with the reference model updated alongside
  task automatic drive_cycle(input logic a, input logic [NB-1:0] b, input logic [NI-1:0] inc,
                             input logic dn, input logic rd);
    m.A_bank = a; m.B_bank = b; m.incident = inc; m.done = dn; m.tr_rd = rd;
    if (rd) begin
      if (exp_q.size() > 0) begin
        chk("rd_head", 64'(m.tr_data), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end else begin
        chk("rd_empty_valid", 64'(m.tr_valid), 64'd0);
      end
    end
    if (a != pa || b != pb || inc != pi) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({TS_W'(m_cyc), a, b, inc});
      else m_ovf = 1'b1;
    end
    if (a != pa) m_a++;
    if (b != pb) m_b++;
    for (int i = 0; i < NI; i++) if (inc[i] && !pi[i]) m_inc++;
    pa = a; pb = b; pi = inc;
    m_cyc++;
    tick();
    m.done = 1'b0; m.tr_rd = 1'b0; m.start = 1'b0;
  endtask

  task automatic start_run(input logic a, input logic [NB-1:0] b, input logic [NI-1:0] inc);
    m.start = 1'b1; m.A_bank = a; m.B_bank = b; m.incident = inc; m.done = 1'b0; m.tr_rd = 1'b0;
    tick();
    m.start = 1'b0;
    exp_q.delete();
    pa = a; pb = b; pi = inc;
    m_a = 0; m_b = 0; m_inc = 0; m_cyc = 0; m_ovf = 1'b0;
    chk("busy_after_start", 64'(m.busy), 64'd1);
  endtask

  task automatic check_end(input string p);
    chk({p, "_cycle_cnt"}, 64'(m.cycle_cnt), 64'(m_cyc));
    chk({p, "_a_sw_cnt"},  64'(m.a_sw_cnt),  64'(m_a));
    chk({p, "_b_sw_cnt"},  64'(m.b_sw_cnt),  64'(m_b));
    chk({p, "_inc_cnt"},   64'(m.inc_cnt),   64'(m_inc));
    chk({p, "_tr_level"},  64'(m.tr_level),  64'(exp_q.size()));
    chk({p, "_tr_ovf"},    64'(m.tr_ovf),    64'(m_ovf));
    chk({p, "_busy"},      64'(m.busy),      64'd0);
    chk({p, "_finished"},  64'(m.finished),  64'd1);
    chk({p, "_timed_out"}, 64'(m.timed_out), 64'd0);
  endtask

  task automatic drain(input string p);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({p, "_valid"}, 64'(m.tr_valid), 64'd1);
      chk({p, "_data"},  64'(m.tr_data),  64'(exp_q[0]));
      void'(exp_q.pop_front());
      m.tr_rd = 1'b1;
      tick();
      m.tr_rd = 1'b0;
    end
    chk({p, "_empty_valid"}, 64'(m.tr_valid), 64'd0);
    chk({p, "_empty_level"}, 64'(m.tr_level), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] bv;
    logic [NI-1:0] iv;
    logic [EW-1:0] first_ent;

    m.start = 1'b0; m.A_bank = 1'b0; m.B_bank = '0; m.incident = '0; m.done = 1'b0; m.tr_rd = 1'b0;
    t.start = 1'b0; t.A_bank = 1'b0; t.B_bank = '0; t.incident = '0; t.done = 1'b0; t.tr_rd = 1'b0;
    pa = 1'b0; pb = '0; pi = '0; m_a = 0; m_b = 0; m_inc = 0; m_cyc = 0; m_ovf = 1'b0;

    // reset state
    rst = 1'b0;
    tick(); tick();
    chk("rst_busy", 64'(m.busy), 64'd0);
    chk("rst_finished", 64'(m.finished), 64'd0);
    chk("rst_cycle_cnt", 64'(m.cycle_cnt), 64'd0);
    chk("rst_tr_valid", 64'(m.tr_valid), 64'd0);
    chk("rst_tr_level", 64'(m.tr_level), 64'd0);
    rst = 1'b1;
    tick();

    // constant inputs, 10 cycles then done
    start_run(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive_cycle(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("t1_cycle_cnt_11", 64'(m.cycle_cnt), 64'd11);
    check_end("t1");
    m.tr_rd = 1'b1;
    tick();
    m.tr_rd = 1'b0;
    chk("t1_rd_empty_level", 64'(m.tr_level), 64'd0);

    // B_bank walking one; pop on empty with simultaneous push at cycle 2; start in RUN ignored
    start_run(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      bv = (i >= 8) ? 4'b1000 : (i >= 6) ? 4'b0100 : (i >= 4) ? 4'b0010 :
           (i >= 2) ? 4'b0001 : 4'b0000;
      if (i == 3) chk("t2_valid_after_push_pop_empty", 64'(m.tr_valid), 64'd1);
      if (i == 5) m.start = 1'b1;
      drive_cycle(1'b0, bv, 4'b0000, i == 9, i == 2);
    end
    chk("t2_b_sw_cnt_4", 64'(m.b_sw_cnt), 64'd4);
    chk("t2_level_4", 64'(m.tr_level), 64'd4);
    first_ent = {16'd2, 1'b0, 4'b0001, 4'b0000};
    chk("t2_first_entry", 64'(m.tr_data), 64'(first_ent));
    check_end("t2");
    drain("t2");

    // incident edges 0000 -> 0101 -> 0111 -> 0000 -> 1000, A_bank flips with the third change
    start_run(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      iv = (i >= 7) ? 4'b1000 : (i >= 5) ? 4'b0000 : (i >= 3) ? 4'b0111 :
           (i >= 1) ? 4'b0101 : 4'b0000;
      drive_cycle(i >= 5, 4'b0000, iv, i == 9, 1'b0);
    end
    chk("t3_inc_cnt_4", 64'(m.inc_cnt), 64'd4);
    chk("t3_a_sw_cnt_1", 64'(m.a_sw_cnt), 64'd1);
    chk("t3_level_4", 64'(m.tr_level), 64'd4);
    check_end("t3");
    drain("t3");

    // timeout at 20 cycles, then done coinciding with the timeout cycle
    t.start = 1'b1;
    tick();
    t.start = 1'b0;
    repeat (19) tick();
    chk("t4_busy_before_tmo", 64'(t.busy), 64'd1);
    chk("t4_cycle_19", 64'(t.cycle_cnt), 64'd19);
    tick();
    chk("t4_busy_after_tmo", 64'(t.busy), 64'd0);
    chk("t4_timed_out", 64'(t.timed_out), 64'd1);
    chk("t4_finished_0", 64'(t.finished), 64'd0);
    chk("t4_cycle_20", 64'(t.cycle_cnt), 64'd20);
    tick();
    chk("t4_cycle_held", 64'(t.cycle_cnt), 64'd20);
    t.start = 1'b1;
    tick();
    t.start = 1'b0;
    chk("t4_restart_clears_tmo", 64'(t.timed_out), 64'd0);
    repeat (19) tick();
    t.done = 1'b1;
    tick();
    t.done = 1'b0;
    chk("t4_tie_finished", 64'(t.finished), 64'd1);
    chk("t4_tie_timed_out", 64'(t.timed_out), 64'd0);
    chk("t4_tie_cycle", 64'(t.cycle_cnt), 64'd20);
    chk("t4_tie_busy", 64'(t.busy), 64'd0);

    // overflow: 20 changes into 16 entries, then push+pop while full
    start_run(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 16; i++) drive_cycle(1'b0, 4'(i + 1), 4'b0000, 1'b0, 1'b0);
    chk("t5_full_level", 64'(m.tr_level), 64'd16);
    chk("t5_full_no_ovf", 64'(m.tr_ovf), 64'd0);
    for (int i = 16; i < 20; i++) drive_cycle(1'b0, 4'(i + 1), 4'b0000, 1'b0, 1'b0);
    chk("t5_level_16", 64'(m.tr_level), 64'd16);
    chk("t5_ovf", 64'(m.tr_ovf), 64'd1);
    drive_cycle(1'b1, 4'(20), 4'b0000, 1'b0, 1'b1);
    chk("t5_pushpop_full_level", 64'(m.tr_level), 64'd16);
    drive_cycle(1'b1, 4'(20), 4'b0000, 1'b1, 1'b0);
    check_end("t5");
    drain("t5");

    // asynchronous reset mid-run with entries queued
    start_run(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 4'(i + 1), 4'b0000, 1'b0, 1'b0);
    chk("t6_level_5", 64'(m.tr_level), 64'd5);
    rst = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(m.busy), 64'd0);
    chk("t6_rst_level", 64'(m.tr_level), 64'd0);
    chk("t6_rst_valid", 64'(m.tr_valid), 64'd0);
    chk("t6_rst_data", 64'(m.tr_data), 64'd0);
    chk("t6_rst_cycle", 64'(m.cycle_cnt), 64'd0);
    chk("t6_rst_b_sw", 64'(m.b_sw_cnt), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    start_run(1'b1, 4'b0011, 4'b0010);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4'b0011, 4'b0010, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'b0011, 4'b0010, 1'b1, 1'b0);
    chk("t6_clean_cycle_4", 64'(m.cycle_cnt), 64'd4);
    check_end("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
